multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Multi-cycle control FSM that sequences the shared MIPS datapath: one ALU, one unified memory port and one register file, reused across cycles. It replaces the single-cycle decoder at the top of the core. Each cycle it drives the PC, IR, memory, register-file and ALU select lines from the current state and the decoded `op`/`funct`, and waits on a ready/request handshake with memory.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  6  IR[31:26]; valid from DECODE onward.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag for the current cycle.
- `mem_ready`  in  1  memory completes the current request.
- `mem_req`  out  1  memory request; held until `mem_ready`.
- `mem_we`  out  1  memory write (sw).
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load IR from memory read data.
- `pc_write`  out  1  update PC.
- `pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `reg_write`  out  1  register-file write.
- `reg_dst`  out  1  destination register: 0 = rd, 1 = rt.
- `mem_to_reg`  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = rs.
- `alu_src_b`  out  2  ALU B input: 00 = rt, 01 = const 4, 10 = extended imm, 11 = sign-ext imm<<2.
- `if_extend`  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- `aluop`  out  5  ALU operation code.
- `illegal`  out  1  one-cycle pulse on an undecodable instruction.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- States: FETCH, DECODE, EXEC, WB_ALU, ADDR, MEM, WB_MEM, BRANCH, JUMP.
- **FETCH:** `mem_req`=1, `iord`=0. ALU computes PC+4 (A=PC, B=4, addu_op). State holds while `mem_ready`=0. On `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=00, next state DECODE.
- **DECODE:** ALU computes branch target (A=PC, B=11, addu_op) into ALUOut. Dispatch:
  - R-type with a supported funct, or addi/addiu/andi/ori/lui → EXEC.
  - lw (100011) or sw (101011) → ADDR.
  - beq (000100) → BRANCH.
  - j (000010) → JUMP.
  - Anything else → FETCH with `illegal`=1. No register or memory write; `retired` does not increment.
- **EXEC:** `alu_src_a`=1. `alu_src_b`=00 for R-type, 10 for I-type. `aluop` and `if_extend` per the decode rules: add/addu/subu/and/or/slt for R-type; addi → add_op, sext; addiu → addu_op, sext; andi → and_op, zext; ori → or_op, zext; lui → lui_op. Next state WB_ALU.
- **WB_ALU:** `reg_write`=1, `mem_to_reg`=0, `reg_dst`=0 for R-type and 1 for I-type. Next FETCH; `retired`+1.
- **ADDR:** A=rs, B=10, `if_extend`=1, addu_op. Next MEM.
- **MEM:** `mem_req`=1, `iord`=1, `mem_we`=(op==sw). Hold until `mem_ready`. Then lw → WB_MEM; sw → FETCH with `retired`+1.
- **WB_MEM:** `reg_write`=1, `reg_dst`=1, `mem_to_reg`=1. Next FETCH; `retired`+1.
- **BRANCH:** A=rs, B=rt, subu_op, `pc_src`=01, `pc_write`=`zero`. Next FETCH; `retired`+1.
- **JUMP:** `pc_write`=1, `pc_src`=10. Next FETCH; `retired`+1.
- All outputs are Moore functions of state plus the decode of `op`/`funct`. Exceptions: `ir_write`/`pc_write` in FETCH and the MEM exit are qualified by `mem_ready`; `pc_write` in BRANCH is qualified by `zero`. Every control output not named in a state is 0.
- `retired` wraps modulo 2^CNT_W.

## Timing
- **Reset:** while `rst`=1, every output is 0 (combinationally gated). At the edge: state ← FETCH, `retired` ← 0.
- **Reset mid-transfer:** `mem_req` drops in the same cycle `rst` rises. The request is abandoned with no write, and a new fetch starts the cycle after `rst` falls.
- **Latency with `mem_ready` tied high:** R/I-ALU 4 cycles, lw 5, sw 4, beq 3, j 3, illegal 2. Each memory wait cycle adds 1.
- **Handshake:** `mem_req`, `iord` and `mem_we` stay stable while waiting. `mem_ready` is ignored when `mem_req`=0.
- **Simultaneous events:** `mem_ready`=1 in the same cycle as `rst`=1 has no effect.

## Structure
- Shared header `ctrl_defs.vh` holds:
  - the opcode and funct codes;
  - the aluop codes: add 00000, addu 00001, subu 00010, and 00011, or 00100, slt 00101, lui 00110;
  - the state encodings;
  - the `pc_src` and `alu_src_b` encodings.
- One combinational sub-module, `ctrl_decode`, maps `op`/`funct` to an instruction class, `aluop`, `if_extend` and a legal flag. The FSM and the counter stay in `multi_cycle_ctrl`.

## Test plan
- addu r3,r1,r2 (op 0, funct 100001), `mem_ready`=1 → states FETCH→DECODE→EXEC→WB_ALU. In WB_ALU: `reg_write`=1, `reg_dst`=0, `aluop`=00001. `retired`=1 after 4 cycles.
- ori (001101) → in EXEC: `if_extend`=0, `alu_src_b`=10, `aluop`=00100. In WB_ALU: `reg_dst`=1.
- lw with `mem_ready` low for 3 cycles in MEM → `mem_req`=1, `iord`=1, `mem_we`=0 held for 4 cycles. Then WB_MEM: `mem_to_reg`=1. Total 8 cycles.
- beq with `zero`=1, then beq with `zero`=0 → `pc_write`=1 with `pc_src`=01, then `pc_write`=0. Each takes 3 cycles.
- op 111111 → `illegal` pulses exactly 1 cycle in DECODE. `reg_write` and `mem_req` stay 0 in DECODE; `retired` unchanged.
- `rst` asserted during a sw MEM wait → `mem_req`=0 and `mem_we`=0 in that cycle. After release: state FETCH, `retired`=0.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, functs,
// ALU operation codes, FSM state encodings and mux select encodings.
package multi_cycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WB_ALU, S_ADDR,
    S_MEM, S_WB_MEM, S_BRANCH, S_JUMP
  } state_t;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_ADDU = 5'b00001,
    ALU_SUBU = 5'b00010,
    ALU_AND  = 5'b00011,
    ALU_OR   = 5'b00100,
    ALU_SLT  = 5'b00101,
    ALU_LUI  = 5'b00110
  } aluop_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_ILL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_RT     = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_BRANCH = 2'b11;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the datapath/memory.
interface multi_cycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             iord;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             if_extend;
  logic [4:0]       aluop;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  op, funct, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, if_extend, aluop,
           illegal, retired
  );

  modport master (
    output op, funct, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, if_extend, aluop,
           illegal, retired
  );
endinterface

// File: rtl/multi_cycle_ctrl_decode.sv
// Instruction decoder: classifies op/funct and picks the ALU operation and
// immediate extension used in the execute/address cycles.
module multi_cycle_ctrl_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output aluop_t     aluop,
  output logic       if_extend,
  output logic       legal
);

  // Opcode/funct lookup; unknown encodings fall through to CLS_ILL.
  always_comb begin
    iclass    = CLS_ILL;
    aluop     = ALU_ADDU;
    if_extend = 1'b0;
    case (op)
      OP_RTYPE: begin
        iclass = CLS_R;
        case (funct)
          FN_ADD:  aluop = ALU_ADD;
          FN_ADDU: aluop = ALU_ADDU;
          FN_SUBU: aluop = ALU_SUBU;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_SLT:  aluop = ALU_SLT;
          default: iclass = CLS_ILL;
        endcase
      end
      OP_ADDI:  begin iclass = CLS_I; aluop = ALU_ADD;  if_extend = 1'b1; end
      OP_ADDIU: begin iclass = CLS_I; aluop = ALU_ADDU; if_extend = 1'b1; end
      OP_ANDI:  begin iclass = CLS_I; aluop = ALU_AND; end
      OP_ORI:   begin iclass = CLS_I; aluop = ALU_OR; end
      OP_LUI:   begin iclass = CLS_I; aluop = ALU_LUI; end
      OP_LW:    begin iclass = CLS_LW; if_extend = 1'b1; end
      OP_SW:    begin iclass = CLS_SW; if_extend = 1'b1; end
      OP_BEQ:   begin iclass = CLS_BEQ; aluop = ALU_SUBU; end
      OP_J:     iclass = CLS_J;
      default:  iclass = CLS_ILL;
    endcase
    legal = (iclass != CLS_ILL);
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM sequencing a shared ALU, memory port and
// register file, plus a retired-instruction counter.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | ALUOut <= branch target, dispatch on instruction class
// EXEC     | ALU op on rs and rt/imm
// WB_ALU   | write ALUOut to rd (R) or rt (I)
// ADDR     | ALUOut <= rs + sign-extended imm
// MEM      | data access at ALUOut, held until mem_ready
// WB_MEM   | write MDR to rt
// BRANCH   | compare rs/rt, PC <= ALUOut when equal
// JUMP     | PC <= jump target
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_cycle_ctrl_if.slave    bus
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  retired_q;
  logic              retire;

  iclass_t dec_class;
  aluop_t  dec_aluop;
  logic    dec_ext;
  logic    dec_legal;

  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, if_extend, illegal;
  aluop_t     aluop;

  multi_cycle_ctrl_decode u_decode (
    .op        (bus.op),
    .funct     (bus.funct),
    .iclass    (dec_class),
    .aluop     (dec_aluop),
    .if_extend (dec_ext),
    .legal     (dec_legal)
  );

  // State register and retired counter; reset wins over any mem_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Next-state and control outputs from state plus decoded instruction.
  always_comb begin
    state_nxt  = state;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_RT;
    if_extend  = 1'b0;
    aluop      = ALU_ADD;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = ALUB_FOUR;
        aluop     = ALU_ADDU;
        if (bus.mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = ALUB_BRANCH;
        aluop     = ALU_ADDU;
        if (!dec_legal) begin
          illegal   = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          case (dec_class)
            CLS_R, CLS_I:   state_nxt = S_EXEC;
            CLS_LW, CLS_SW: state_nxt = S_ADDR;
            CLS_BEQ:        state_nxt = S_BRANCH;
            default:        state_nxt = S_JUMP;
          endcase
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = (dec_class == CLS_R) ? ALUB_RT : ALUB_IMM;
        aluop     = dec_aluop;
        if_extend = dec_ext;
        state_nxt = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = (dec_class != CLS_R);
        aluop     = dec_aluop;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        if_extend = 1'b1;
        aluop     = ALU_ADDU;
        state_nxt = S_MEM;
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (dec_class == CLS_SW);
        if (bus.mem_ready) begin
          if (dec_class == CLS_SW) begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB_MEM;
          end
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_RT;
        aluop     = ALU_SUBU;
        pc_src    = PC_SRC_ALUOUT;
        pc_write  = bus.zero;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_src    = PC_SRC_JUMP;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Reset forces every output low in the same cycle, abandoning any request.
  assign bus.mem_req    = !rst && mem_req;
  assign bus.mem_we     = !rst && mem_we;
  assign bus.iord       = !rst && iord;
  assign bus.ir_write   = !rst && ir_write;
  assign bus.pc_write   = !rst && pc_write;
  assign bus.pc_src     = rst ? 2'b00 : pc_src;
  assign bus.reg_write  = !rst && reg_write;
  assign bus.reg_dst    = !rst && reg_dst;
  assign bus.mem_to_reg = !rst && mem_to_reg;
  assign bus.alu_src_a  = !rst && alu_src_a;
  assign bus.alu_src_b  = rst ? 2'b00 : alu_src_b;
  assign bus.if_extend  = !rst && if_extend;
  assign bus.aluop      = rst ? 5'b00000 : aluop;
  assign bus.illegal    = !rst && illegal;
  assign bus.retired    = rst ? '0 : retired_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: each instruction is expanded into a queue of
// expected per-cycle control words from the instruction's behaviour, with
// random memory wait states, random zero and random mem_ready outside
// memory cycles.
module tb_multi_cycle_ctrl;
  import multi_cycle_ctrl_pkg::*;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_cycle_ctrl_if #(.CNT_W(CW)) bus ();
  multi_cycle_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic       if_extend;
    logic [4:0] aluop;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic  rdy;
    logic  z;
    ctl_t  exp;
    string tag;
  } step_t;

  typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    kind_t      k;
    logic [4:0] alu;
    logic       ext;
  } instr_t;

  instr_t tbl [17];
  step_t  q [$];
  int     checks = 0;
  int     failures = 0;
  int     exp_ret = 0;
  int     cur = 0;

  function automatic ctl_t observe();
    ctl_t c;
    c.mem_req = bus.mem_req;      c.mem_we = bus.mem_we;
    c.iord = bus.iord;            c.ir_write = bus.ir_write;
    c.pc_write = bus.pc_write;    c.pc_src = bus.pc_src;
    c.reg_write = bus.reg_write;  c.reg_dst = bus.reg_dst;
    c.mem_to_reg = bus.mem_to_reg; c.alu_src_a = bus.alu_src_a;
    c.alu_src_b = bus.alu_src_b;  c.if_extend = bus.if_extend;
    c.aluop = bus.aluop;          c.illegal = bus.illegal;
    return c;
  endfunction

  function automatic ctl_t fetch_ctl(input logic done);
    ctl_t c = '0;
    c.mem_req = 1'b1; c.alu_src_b = 2'b01; c.aluop = 5'b00001;
    c.ir_write = done; c.pc_write = done;
    return c;
  endfunction

  task automatic chk_ctl(input ctl_t exp, input string tag);
    ctl_t obs;
    obs = observe();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s instr=%0d observed=%h expected=%h", tag, cur, obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag);
    checks++;
    assert (bus.retired === CW'(exp_ret)) else begin
      failures++;
      $error("FAIL %s instr=%0d observed=%0d expected=%0d", tag, cur, bus.retired, exp_ret);
    end
  endtask

  task automatic push(input logic rdy, input logic z, input ctl_t c, input string tag);
    step_t s;
    s.rdy = rdy; s.z = z; s.exp = c; s.tag = tag;
    q.push_back(s);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction.
  task automatic plan(input int idx, input int fw, input int mw, input logic z);
    instr_t e = tbl[idx];
    ctl_t c;
    for (int i = 0; i < fw; i++) push(1'b0, rbit(), fetch_ctl(1'b0), "fetch_wait");
    push(1'b1, rbit(), fetch_ctl(1'b1), "fetch_done");
    c = '0; c.alu_src_b = 2'b11; c.aluop = 5'b00001; c.illegal = (e.k == K_ILL);
    push(rbit(), rbit(), c, "decode");
    case (e.k)
      K_R, K_I: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = (e.k == K_R) ? 2'b00 : 2'b10;
        c.aluop = e.alu; c.if_extend = e.ext;
        push(rbit(), rbit(), c, "exec");
        c = '0; c.reg_write = 1'b1; c.reg_dst = (e.k == K_I); c.aluop = e.alu;
        push(rbit(), rbit(), c, "wb_alu");
      end
      K_LW, K_SW: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.if_extend = 1'b1;
        c.aluop = 5'b00001;
        push(rbit(), rbit(), c, "addr");
        c = '0; c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = (e.k == K_SW);
        for (int i = 0; i < mw; i++) push(1'b0, rbit(), c, "mem_wait");
        push(1'b1, rbit(), c, "mem_done");
        if (e.k == K_LW) begin
          c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1; c.mem_to_reg = 1'b1;
          push(rbit(), rbit(), c, "wb_mem");
        end
      end
      K_BEQ: begin
        c = '0; c.alu_src_a = 1'b1; c.aluop = 5'b00010; c.pc_src = 2'b01;
        c.pc_write = z;
        push(rbit(), z, c, "branch");
      end
      K_J: begin
        c = '0; c.pc_write = 1'b1; c.pc_src = 2'b10;
        push(rbit(), rbit(), c, "jump");
      end
      default: ;
    endcase
  endtask

  task automatic drain();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      bus.mem_ready = s.rdy;
      bus.zero = s.z;
      @(negedge clk);
      chk_ctl(s.exp, s.tag);
      @(posedge clk); #1;
    end
  endtask

  task automatic set_instr(input int idx);
    cur++;
    bus.op = tbl[idx].op;
    bus.funct = (tbl[idx].op == 6'b000000) ? tbl[idx].fn : 6'($urandom_range(0, 63));
  endtask

  task automatic run(input int idx, input int fw, input int mw, input logic z);
    set_instr(idx);
    plan(idx, fw, mw, z);
    drain();
    if (tbl[idx].k != K_ILL) exp_ret = (exp_ret + 1) % (1 << CW);
    chk_ret("retired");
  endtask

  initial begin
    tbl[0]  = '{6'b000000, 6'b100000, K_R,   5'b00000, 1'b0};
    tbl[1]  = '{6'b000000, 6'b100001, K_R,   5'b00001, 1'b0};
    tbl[2]  = '{6'b000000, 6'b100011, K_R,   5'b00010, 1'b0};
    tbl[3]  = '{6'b000000, 6'b100100, K_R,   5'b00011, 1'b0};
    tbl[4]  = '{6'b000000, 6'b100101, K_R,   5'b00100, 1'b0};
    tbl[5]  = '{6'b000000, 6'b101010, K_R,   5'b00101, 1'b0};
    tbl[6]  = '{6'b001000, 6'b000000, K_I,   5'b00000, 1'b1};
    tbl[7]  = '{6'b001001, 6'b000000, K_I,   5'b00001, 1'b1};
    tbl[8]  = '{6'b001100, 6'b000000, K_I,   5'b00011, 1'b0};
    tbl[9]  = '{6'b001101, 6'b000000, K_I,   5'b00100, 1'b0};
    tbl[10] = '{6'b001111, 6'b000000, K_I,   5'b00110, 1'b0};
    tbl[11] = '{6'b100011, 6'b000000, K_LW,  5'b00000, 1'b0};
    tbl[12] = '{6'b101011, 6'b000000, K_SW,  5'b00000, 1'b0};
    tbl[13] = '{6'b000100, 6'b000000, K_BEQ, 5'b00000, 1'b0};
    tbl[14] = '{6'b000010, 6'b000000, K_J,   5'b00000, 1'b0};
    tbl[15] = '{6'b111111, 6'b000000, K_ILL, 5'b00000, 1'b0};
    tbl[16] = '{6'b000000, 6'b001000, K_ILL, 5'b00000, 1'b0};

    rst = 1'b1;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk_ctl('0, "reset_ctl");
    chk_ret("reset_retired");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_ready = 1'b0;

    run(1, 0, 0, 1'b0);    // addu
    run(9, 0, 0, 1'b0);    // ori
    run(11, 0, 3, 1'b0);   // lw with 3 memory wait cycles
    run(13, 0, 0, 1'b1);   // beq taken
    run(13, 0, 0, 1'b0);   // beq not taken
    run(15, 0, 0, 1'b0);   // undefined opcode
    run(16, 0, 0, 1'b0);   // R-type with unsupported funct
    run(14, 1, 0, 1'b0);   // j
    run(12, 2, 1, 1'b0);   // sw
    run(10, 0, 0, 1'b0);   // lui
    run(6, 3, 0, 1'b0);    // addi

    for (int n = 0; n < 60; n++)
      run($urandom_range(0, 16), $urandom_range(0, 3), $urandom_range(0, 3), rbit());

    // Reset while a store waits in MEM, with mem_ready arriving alongside.
    if (exp_ret == 0) run(0, 0, 0, 1'b0);
    set_instr(12);
    plan(12, 0, 1, 1'b0);
    void'(q.pop_back());
    drain();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    exp_ret = 0;
    @(negedge clk);
    chk_ctl('0, "rst_mid_sw_ctl");
    chk_ret("rst_mid_sw_retired");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk_ctl(fetch_ctl(1'b0), "post_rst_fetch");
    chk_ret("post_rst_retired");
    @(posedge clk); #1;

    run(7, 0, 0, 1'b0);
    run(11, 1, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
